tl_xbar_arb_2to1: RTL and testbench

Two-client TileLink-UH arbiter that merges client ports in0 and in1 onto one manager-side port. It sits upstream of a TLBuffer pass-through stage on the 64-bit, 29-bit-address peripheral bus. The A channel is arbitrated round-robin, and multi-beat Put bursts are locked to a single owner. The client index is prefixed onto the A source, and D responses are routed back by that prefix.

---
 rtl/tl_xbar_arb_2to1.sv | 195 +++++++++++++++++++
 tb/tb_tl_xbar_arb_2to1.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_xbar_arb_2to1.sv
// Two-client TileLink-UH A/D arbiter onto one manager port.
// A channel: round-robin between in0/in1, multi-beat Put bursts locked to
// one owner. The client index is prefixed onto the A source as bit 6.
// D channel: routed back to the client named by source bit 6, with no state.
module tl_xbar_arb_2to1 (
  input  logic        clock,
  input  logic        reset,

  input  logic        auto_in0_a_valid,
  output logic        auto_in0_a_ready,
  input  logic [2:0]  auto_in0_a_bits_opcode,
  input  logic [2:0]  auto_in0_a_bits_param,
  input  logic [3:0]  auto_in0_a_bits_size,
  input  logic [5:0]  auto_in0_a_bits_source,
  input  logic [28:0] auto_in0_a_bits_address,
  input  logic [7:0]  auto_in0_a_bits_mask,
  input  logic [63:0] auto_in0_a_bits_data,
  input  logic        auto_in0_a_bits_corrupt,
  output logic        auto_in0_d_valid,
  input  logic        auto_in0_d_ready,
  output logic [2:0]  auto_in0_d_bits_opcode,
  output logic [1:0]  auto_in0_d_bits_param,
  output logic [3:0]  auto_in0_d_bits_size,
  output logic [5:0]  auto_in0_d_bits_source,
  output logic        auto_in0_d_bits_sink,
  output logic        auto_in0_d_bits_denied,
  output logic [63:0] auto_in0_d_bits_data,
  output logic        auto_in0_d_bits_corrupt,

  input  logic        auto_in1_a_valid,
  output logic        auto_in1_a_ready,
  input  logic [2:0]  auto_in1_a_bits_opcode,
  input  logic [2:0]  auto_in1_a_bits_param,
  input  logic [3:0]  auto_in1_a_bits_size,
  input  logic [5:0]  auto_in1_a_bits_source,
  input  logic [28:0] auto_in1_a_bits_address,
  input  logic [7:0]  auto_in1_a_bits_mask,
  input  logic [63:0] auto_in1_a_bits_data,
  input  logic        auto_in1_a_bits_corrupt,
  output logic        auto_in1_d_valid,
  input  logic        auto_in1_d_ready,
  output logic [2:0]  auto_in1_d_bits_opcode,
  output logic [1:0]  auto_in1_d_bits_param,
  output logic [3:0]  auto_in1_d_bits_size,
  output logic [5:0]  auto_in1_d_bits_source,
  output logic        auto_in1_d_bits_sink,
  output logic        auto_in1_d_bits_denied,
  output logic [63:0] auto_in1_d_bits_data,
  output logic        auto_in1_d_bits_corrupt,

  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [6:0]  auto_out_a_bits_source,
  output logic [28:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [6:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt
);

  logic        locked;
  logic        owner;
  logic [11:0] beats_left;
  logic        last_grant;

  logic        grant;
  logic        grant_active;
  logic        a_fire;
  logic        multi_beat;
  logic [11:0] beats_m1;
  logic        d_sel;

  // Grant selection: the lock owner wins outright, otherwise round-robin on ties.
  always_comb begin
    grant        = 1'b0;
    grant_active = 1'b0;
    if (locked) begin
      grant        = owner;
      grant_active = 1'b1;
    end else if (auto_in0_a_valid && !auto_in1_a_valid) begin
      grant        = 1'b0;
      grant_active = 1'b1;
    end else if (auto_in1_a_valid && !auto_in0_a_valid) begin
      grant        = 1'b1;
      grant_active = 1'b1;
    end else if (auto_in0_a_valid && auto_in1_a_valid) begin
      grant        = ~last_grant;
      grant_active = 1'b1;
    end
  end

  // A payload mux from the granted client; source gets the client index prefix.
  always_comb begin
    if (grant) begin
      auto_out_a_valid        = auto_in1_a_valid;
      auto_out_a_bits_opcode  = auto_in1_a_bits_opcode;
      auto_out_a_bits_param   = auto_in1_a_bits_param;
      auto_out_a_bits_size    = auto_in1_a_bits_size;
      auto_out_a_bits_source  = {1'b1, auto_in1_a_bits_source};
      auto_out_a_bits_address = auto_in1_a_bits_address;
      auto_out_a_bits_mask    = auto_in1_a_bits_mask;
      auto_out_a_bits_data    = auto_in1_a_bits_data;
      auto_out_a_bits_corrupt = auto_in1_a_bits_corrupt;
    end else begin
      auto_out_a_valid        = auto_in0_a_valid;
      auto_out_a_bits_opcode  = auto_in0_a_bits_opcode;
      auto_out_a_bits_param   = auto_in0_a_bits_param;
      auto_out_a_bits_size    = auto_in0_a_bits_size;
      auto_out_a_bits_source  = {1'b0, auto_in0_a_bits_source};
      auto_out_a_bits_address = auto_in0_a_bits_address;
      auto_out_a_bits_mask    = auto_in0_a_bits_mask;
      auto_out_a_bits_data    = auto_in0_a_bits_data;
      auto_out_a_bits_corrupt = auto_in0_a_bits_corrupt;
    end
  end

  // Only the granted client sees the manager's ready; with no grant both stay low.
  always_comb begin
    auto_in0_a_ready = grant_active & ~grant & auto_out_a_ready;
    auto_in1_a_ready = grant_active &  grant & auto_out_a_ready;
  end

  // Burst length of the message now on the bus, as beats minus one.
  // For a Put of size s the remaining beats are (1 << (s-3)) - 1, i.e. s-3 low ones.
  always_comb begin
    a_fire     = auto_out_a_valid & auto_out_a_ready;
    multi_beat = (auto_out_a_bits_opcode[2:1] == 2'b00) && (auto_out_a_bits_size > 4'd3);
    beats_m1   = 12'hfff >> (4'd15 - auto_out_a_bits_size);
  end

  // Arbitration state: lock on the first beat of a burst, release on its last beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      locked     <= 1'b0;
      owner      <= 1'b0;
      beats_left <= 12'd0;
      last_grant <= 1'b1;
    end else if (a_fire) begin
      if (!locked) begin
        if (multi_beat) begin
          locked     <= 1'b1;
          owner      <= grant;
          beats_left <= beats_m1;
        end else begin
          last_grant <= grant;
        end
      end else begin
        beats_left <= beats_left - 12'd1;
        if (beats_left == 12'd1) begin
          locked     <= 1'b0;
          last_grant <= owner;
        end
      end
    end
  end

  // D routing by source bit 6; the prefix is stripped on the way back.
  always_comb begin
    d_sel            = auto_out_d_bits_source[6];
    auto_in0_d_valid = auto_out_d_valid & ~d_sel;
    auto_in1_d_valid = auto_out_d_valid &  d_sel;
    auto_out_d_ready = d_sel ? auto_in1_d_ready : auto_in0_d_ready;

    auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
    auto_in0_d_bits_param   = auto_out_d_bits_param;
    auto_in0_d_bits_size    = auto_out_d_bits_size;
    auto_in0_d_bits_source  = auto_out_d_bits_source[5:0];
    auto_in0_d_bits_sink    = auto_out_d_bits_sink;
    auto_in0_d_bits_denied  = auto_out_d_bits_denied;
    auto_in0_d_bits_data    = auto_out_d_bits_data;
    auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;

    auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
    auto_in1_d_bits_param   = auto_out_d_bits_param;
    auto_in1_d_bits_size    = auto_out_d_bits_size;
    auto_in1_d_bits_source  = auto_out_d_bits_source[5:0];
    auto_in1_d_bits_sink    = auto_out_d_bits_sink;
    auto_in1_d_bits_denied  = auto_out_d_bits_denied;
    auto_in1_d_bits_data    = auto_out_d_bits_data;
    auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;
  end

endmodule

// File: tb/tb_tl_xbar_arb_2to1.sv
// Bench for tl_xbar_arb_2to1: vector table, directed burst/reset sequences,
// then randomized traffic against a message-level reference model.
module tb_tl_xbar_arb_2to1;

  logic        clock;
  logic        reset;

  logic        auto_in0_a_valid, auto_in0_a_ready;
  logic [2:0]  auto_in0_a_bits_opcode, auto_in0_a_bits_param;
  logic [3:0]  auto_in0_a_bits_size;
  logic [5:0]  auto_in0_a_bits_source;
  logic [28:0] auto_in0_a_bits_address;
  logic [7:0]  auto_in0_a_bits_mask;
  logic [63:0] auto_in0_a_bits_data;
  logic        auto_in0_a_bits_corrupt;
  logic        auto_in0_d_valid, auto_in0_d_ready;
  logic [2:0]  auto_in0_d_bits_opcode;
  logic [1:0]  auto_in0_d_bits_param;
  logic [3:0]  auto_in0_d_bits_size;
  logic [5:0]  auto_in0_d_bits_source;
  logic        auto_in0_d_bits_sink, auto_in0_d_bits_denied, auto_in0_d_bits_corrupt;
  logic [63:0] auto_in0_d_bits_data;

  logic        auto_in1_a_valid, auto_in1_a_ready;
  logic [2:0]  auto_in1_a_bits_opcode, auto_in1_a_bits_param;
  logic [3:0]  auto_in1_a_bits_size;
  logic [5:0]  auto_in1_a_bits_source;
  logic [28:0] auto_in1_a_bits_address;
  logic [7:0]  auto_in1_a_bits_mask;
  logic [63:0] auto_in1_a_bits_data;
  logic        auto_in1_a_bits_corrupt;
  logic        auto_in1_d_valid, auto_in1_d_ready;
  logic [2:0]  auto_in1_d_bits_opcode;
  logic [1:0]  auto_in1_d_bits_param;
  logic [3:0]  auto_in1_d_bits_size;
  logic [5:0]  auto_in1_d_bits_source;
  logic        auto_in1_d_bits_sink, auto_in1_d_bits_denied, auto_in1_d_bits_corrupt;
  logic [63:0] auto_in1_d_bits_data;

  logic        auto_out_a_valid, auto_out_a_ready;
  logic [2:0]  auto_out_a_bits_opcode, auto_out_a_bits_param;
  logic [3:0]  auto_out_a_bits_size;
  logic [6:0]  auto_out_a_bits_source;
  logic [28:0] auto_out_a_bits_address;
  logic [7:0]  auto_out_a_bits_mask;
  logic [63:0] auto_out_a_bits_data;
  logic        auto_out_a_bits_corrupt;
  logic        auto_out_d_valid, auto_out_d_ready;
  logic [2:0]  auto_out_d_bits_opcode;
  logic [1:0]  auto_out_d_bits_param;
  logic [3:0]  auto_out_d_bits_size;
  logic [6:0]  auto_out_d_bits_source;
  logic        auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_corrupt;
  logic [63:0] auto_out_d_bits_data;

  tl_xbar_arb_2to1 dut (
    .clock(clock), .reset(reset),
    .auto_in0_a_valid(auto_in0_a_valid), .auto_in0_a_ready(auto_in0_a_ready),
    .auto_in0_a_bits_opcode(auto_in0_a_bits_opcode), .auto_in0_a_bits_param(auto_in0_a_bits_param),
    .auto_in0_a_bits_size(auto_in0_a_bits_size), .auto_in0_a_bits_source(auto_in0_a_bits_source),
    .auto_in0_a_bits_address(auto_in0_a_bits_address), .auto_in0_a_bits_mask(auto_in0_a_bits_mask),
    .auto_in0_a_bits_data(auto_in0_a_bits_data), .auto_in0_a_bits_corrupt(auto_in0_a_bits_corrupt),
    .auto_in0_d_valid(auto_in0_d_valid), .auto_in0_d_ready(auto_in0_d_ready),
    .auto_in0_d_bits_opcode(auto_in0_d_bits_opcode), .auto_in0_d_bits_param(auto_in0_d_bits_param),
    .auto_in0_d_bits_size(auto_in0_d_bits_size), .auto_in0_d_bits_source(auto_in0_d_bits_source),
    .auto_in0_d_bits_sink(auto_in0_d_bits_sink), .auto_in0_d_bits_denied(auto_in0_d_bits_denied),
    .auto_in0_d_bits_data(auto_in0_d_bits_data), .auto_in0_d_bits_corrupt(auto_in0_d_bits_corrupt),
    .auto_in1_a_valid(auto_in1_a_valid), .auto_in1_a_ready(auto_in1_a_ready),
    .auto_in1_a_bits_opcode(auto_in1_a_bits_opcode), .auto_in1_a_bits_param(auto_in1_a_bits_param),
    .auto_in1_a_bits_size(auto_in1_a_bits_size), .auto_in1_a_bits_source(auto_in1_a_bits_source),
    .auto_in1_a_bits_address(auto_in1_a_bits_address), .auto_in1_a_bits_mask(auto_in1_a_bits_mask),
    .auto_in1_a_bits_data(auto_in1_a_bits_data), .auto_in1_a_bits_corrupt(auto_in1_a_bits_corrupt),
    .auto_in1_d_valid(auto_in1_d_valid), .auto_in1_d_ready(auto_in1_d_ready),
    .auto_in1_d_bits_opcode(auto_in1_d_bits_opcode), .auto_in1_d_bits_param(auto_in1_d_bits_param),
    .auto_in1_d_bits_size(auto_in1_d_bits_size), .auto_in1_d_bits_source(auto_in1_d_bits_source),
    .auto_in1_d_bits_sink(auto_in1_d_bits_sink), .auto_in1_d_bits_denied(auto_in1_d_bits_denied),
    .auto_in1_d_bits_data(auto_in1_d_bits_data), .auto_in1_d_bits_corrupt(auto_in1_d_bits_corrupt),
    .auto_out_a_valid(auto_out_a_valid), .auto_out_a_ready(auto_out_a_ready),
    .auto_out_a_bits_opcode(auto_out_a_bits_opcode), .auto_out_a_bits_param(auto_out_a_bits_param),
    .auto_out_a_bits_size(auto_out_a_bits_size), .auto_out_a_bits_source(auto_out_a_bits_source),
    .auto_out_a_bits_address(auto_out_a_bits_address), .auto_out_a_bits_mask(auto_out_a_bits_mask),
    .auto_out_a_bits_data(auto_out_a_bits_data), .auto_out_a_bits_corrupt(auto_out_a_bits_corrupt),
    .auto_out_d_valid(auto_out_d_valid), .auto_out_d_ready(auto_out_d_ready),
    .auto_out_d_bits_opcode(auto_out_d_bits_opcode), .auto_out_d_bits_param(auto_out_d_bits_param),
    .auto_out_d_bits_size(auto_out_d_bits_size), .auto_out_d_bits_source(auto_out_d_bits_source),
    .auto_out_d_bits_sink(auto_out_d_bits_sink), .auto_out_d_bits_denied(auto_out_d_bits_denied),
    .auto_out_d_bits_data(auto_out_d_bits_data), .auto_out_d_bits_corrupt(auto_out_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: which client owns an in-progress burst (-1 = none),
  // how many beats of it are still to come, and who won the last arbitration.
  int m_owner = -1;
  int m_rem   = 0;
  int m_last  = 1;

  // Values captured from the DUT in the most recent cycle.
  logic       c_ov, c_r0, c_r1, c_dv0, c_dv1, c_odr;
  logic [6:0] c_src;
  int         last_g;
  logic       last_fire;

  typedef struct {
    logic v0, v1;
    logic [5:0] s0, s1;
    logic ordy, dv;
    logic [6:0] dsrc;
    logic dr0, dr1;
    logic e_ov;
    logic [6:0] e_src;
    logic e_r0, e_r1, e_dv0, e_dv1, e_odr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
    if ((op == 3'd0 || op == 3'd1) && sz > 4'd3) return 2 ** (int'(sz) - 3);
    return 1;
  endfunction

  function automatic int model_grant();
    if (m_owner >= 0) return m_owner;
    if (auto_in0_a_valid && !auto_in1_a_valid) return 0;
    if (auto_in1_a_valid && !auto_in0_a_valid) return 1;
    if (auto_in0_a_valid && auto_in1_a_valid) return 1 - m_last;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rem   = 0;
    m_last  = 1;
  endtask

  // One clock: compare combinational outputs with the model, then step both.
  task automatic cycle();
    int g;
    logic ev, fire;
    logic [6:0] esrc;
    logic [2:0] op;
    logic [3:0] sz;
    #2;
    g  = model_grant();
    ev = (g == 0) ? auto_in0_a_valid : (g == 1) ? auto_in1_a_valid : 1'b0;
    c_ov = auto_out_a_valid; c_r0 = auto_in0_a_ready; c_r1 = auto_in1_a_ready;
    c_src = auto_out_a_bits_source; c_dv0 = auto_in0_d_valid; c_dv1 = auto_in1_d_valid;
    c_odr = auto_out_d_ready;
    chk("out_a_valid", auto_out_a_valid, ev);
    chk("in0_a_ready", auto_in0_a_ready, (g == 0) && auto_out_a_ready);
    chk("in1_a_ready", auto_in1_a_ready, (g == 1) && auto_out_a_ready);
    if (ev) begin
      esrc = (g == 1) ? {1'b1, auto_in1_a_bits_source} : {1'b0, auto_in0_a_bits_source};
      chk("out_a_source", auto_out_a_bits_source, esrc);
      chk("out_a_address", auto_out_a_bits_address,
          (g == 1) ? auto_in1_a_bits_address : auto_in0_a_bits_address);
      chk("out_a_data", auto_out_a_bits_data,
          (g == 1) ? auto_in1_a_bits_data : auto_in0_a_bits_data);
    end
    chk("in0_d_valid", auto_in0_d_valid, auto_out_d_valid && (auto_out_d_bits_source >= 7'd64) == 1'b0);
    chk("in1_d_valid", auto_in1_d_valid, auto_out_d_valid && (auto_out_d_bits_source >= 7'd64));
    chk("out_d_ready", auto_out_d_ready,
        (auto_out_d_bits_source >= 7'd64) ? auto_in1_d_ready : auto_in0_d_ready);
    chk("in0_d_source", auto_in0_d_bits_source, auto_out_d_bits_source % 64);
    chk("in1_d_data", auto_in1_d_bits_data, auto_out_d_bits_data);
    fire = ev && auto_out_a_ready;
    op = (g == 1) ? auto_in1_a_bits_opcode : auto_in0_a_bits_opcode;
    sz = (g == 1) ? auto_in1_a_bits_size : auto_in0_a_bits_size;
    @(posedge clock);
    if (reset && fire) begin
      if (m_owner < 0) begin
        if (beats_of(op, sz) > 1) begin
          m_owner = g;
          m_rem   = beats_of(op, sz) - 1;
        end else begin
          m_last = g;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
    last_g    = g;
    last_fire = fire;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic set_a0(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [5:0] src);
    auto_in0_a_valid = v; auto_in0_a_bits_opcode = op; auto_in0_a_bits_size = sz;
    auto_in0_a_bits_source = src;
  endtask

  task automatic set_a1(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [5:0] src);
    auto_in1_a_valid = v; auto_in1_a_bits_opcode = op; auto_in1_a_bits_size = sz;
    auto_in1_a_bits_source = src;
  endtask

  task automatic randomize_inputs();
    logic [2:0] ops[3];
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
    set_a0($urandom_range(0, 3) != 0, ops[$urandom_range(0, 2)], 4'($urandom_range(0, 7)),
           6'($urandom));
    set_a1($urandom_range(0, 3) != 0, ops[$urandom_range(0, 2)], 4'($urandom_range(0, 7)),
           6'($urandom));
    auto_in0_a_bits_address = 29'($urandom); auto_in1_a_bits_address = 29'($urandom);
    auto_in0_a_bits_data = {$urandom, $urandom}; auto_in1_a_bits_data = {$urandom, $urandom};
    auto_out_a_ready = $urandom_range(0, 3) != 0;
    auto_out_d_valid = 1'($urandom); auto_out_d_bits_source = 7'($urandom);
    auto_out_d_bits_data = {$urandom, $urandom};
    auto_in0_d_ready = 1'($urandom); auto_in1_d_ready = 1'($urandom);
  endtask

  initial begin
    int n;
    clock = 1'b0;
    reset = 1'b0;
    set_a0(0, 3'd4, 4'd3, 6'd3);
    set_a1(0, 3'd4, 4'd3, 6'd9);
    auto_in0_a_bits_param = '0; auto_in0_a_bits_mask = '1; auto_in0_a_bits_corrupt = 0;
    auto_in1_a_bits_param = '0; auto_in1_a_bits_mask = '1; auto_in1_a_bits_corrupt = 0;
    auto_in0_a_bits_address = 29'h100; auto_in1_a_bits_address = 29'h200;
    auto_in0_a_bits_data = 64'h0a0a; auto_in1_a_bits_data = 64'h1b1b;
    auto_out_a_ready = 1'b0;
    auto_out_d_valid = 1'b0; auto_out_d_bits_opcode = 3'd1; auto_out_d_bits_param = '0;
    auto_out_d_bits_size = 4'd4; auto_out_d_bits_source = '0; auto_out_d_bits_sink = 0;
    auto_out_d_bits_denied = 0; auto_out_d_bits_data = 64'hd00d; auto_out_d_bits_corrupt = 0;
    auto_in0_d_ready = 1'b0; auto_in1_d_ready = 1'b0;

    //           v0 v1 s0 s1 ordy dv dsrc    dr0 dr1 ov  src     r0 r1 dv0 dv1 odr
    vecs[0] = '{1, 1, 3, 9, 1, 0, 7'h00, 1, 0, 1, 7'h03, 1, 0, 0, 0, 1};
    vecs[1] = '{1, 1, 3, 9, 1, 0, 7'h00, 1, 0, 1, 7'h49, 0, 1, 0, 0, 1};
    vecs[2] = '{1, 1, 3, 9, 1, 0, 7'h00, 1, 0, 1, 7'h03, 1, 0, 0, 0, 1};
    vecs[3] = '{1, 1, 3, 9, 1, 0, 7'h00, 1, 0, 1, 7'h49, 0, 1, 0, 0, 1};
    vecs[4] = '{0, 0, 3, 9, 1, 1, 7'h45, 0, 1, 0, 7'h00, 0, 0, 0, 1, 1};
    vecs[5] = '{1, 0, 3, 9, 0, 1, 7'h05, 0, 1, 1, 7'h03, 0, 0, 1, 0, 0};
    vecs[6] = '{0, 1, 3, 9, 1, 1, 7'h45, 1, 0, 1, 7'h49, 0, 1, 0, 1, 0};
    vecs[7] = '{1, 1, 3, 9, 1, 0, 7'h05, 1, 1, 1, 7'h03, 1, 0, 0, 0, 1};

    apply_reset();

    // Vector table: alternating Gets, then D routing with mixed readies.
    for (int i = 0; i < 8; i++) begin
      set_a0(vecs[i].v0, 3'd4, 4'd3, vecs[i].s0);
      set_a1(vecs[i].v1, 3'd4, 4'd3, vecs[i].s1);
      auto_out_a_ready = vecs[i].ordy;
      auto_out_d_valid = vecs[i].dv; auto_out_d_bits_source = vecs[i].dsrc;
      auto_in0_d_ready = vecs[i].dr0; auto_in1_d_ready = vecs[i].dr1;
      cycle();
      chk("vec_ov", c_ov, vecs[i].e_ov);
      if (vecs[i].e_ov) chk("vec_src", c_src, vecs[i].e_src);
      chk("vec_r0", c_r0, vecs[i].e_r0);
      chk("vec_r1", c_r1, vecs[i].e_r1);
      chk("vec_dv0", c_dv0, vecs[i].e_dv0);
      chk("vec_dv1", c_dv1, vecs[i].e_dv1);
      chk("vec_odr", c_odr, vecs[i].e_odr);
    end

    // Burst lock: 8-beat Put from in0 while in1 keeps asking.
    auto_out_d_valid = 1'b0;
    apply_reset();
    set_a0(1, 3'd0, 4'd6, 6'd1);
    set_a1(1, 3'd4, 4'd3, 6'd2);
    auto_out_a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("lock_in0_beat", {c_ov, c_src[6]}, 2'b10);
      chk("lock_in1_rdy", c_r1, 1'b0);
    end
    cycle();
    chk("lock_release_in1", {c_ov, c_src[6]}, 2'b11);

    // Burst stall: manager backpressure, then owner drops valid, mid-burst.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_beat_a", {c_ov, c_src[6]}, 2'b10);
    end
    auto_out_a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready_low", {c_ov, c_src[6], c_r1}, 3'b100);
    end
    auto_out_a_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_beat_b", {c_ov, c_src[6]}, 2'b10);
    end
    auto_in0_a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_owner_idle", {c_ov, c_r1}, 2'b00);
    end
    auto_in0_a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_beat_c", {c_ov, c_src[6]}, 2'b10);
    end
    cycle();
    chk("stall_release_in1", {c_ov, c_src[6]}, 2'b11);

    // Reset mid-burst: in1 owns an 8-beat Put, reset after 3 beats.
    apply_reset();
    set_a0(0, 3'd4, 4'd3, 6'd4);
    set_a1(1, 3'd1, 4'd6, 6'd5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_in1_beat", {c_ov, c_src[6]}, 2'b11);
    end
    auto_in0_a_valid = 1'b1;
    reset = 1'b0;
    model_reset();
    cycle();
    chk("rst_during_grant", {c_ov, c_src[6], c_r1}, 3'b100);
    reset = 1'b1;
    cycle();
    chk("rst_first_grant_in0", {last_fire, c_src[6]}, 2'b10);

    // Maximum size: 4096-beat Put from in0, then in1 gets its turn.
    apply_reset();
    set_a0(1, 3'd0, 4'd15, 6'd7);
    set_a1(1, 3'd4, 4'd3, 6'd8);
    auto_out_a_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      cycle();
      if (last_fire && last_g == 1) break;
      if (last_fire && last_g == 0) n++;
    end
    chk("max_beats", n, 4096);
    chk("max_next_in1", {last_fire, c_src[6]}, 2'b11);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
